m1_rd_arbiter: RTL and testbench

M1_RD_ARBITER -- requirements
Module: m1_rd_arbiter

---
 rtl/m1_rd_arbiter.sv | 132 +++++++++++++
 tb/tb_m1_rd_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/m1_rd_arbiter.sv
// Round-robin read arbiter that shares one RAM user port among N_REQ requesters.
// Each grant issues one registered read and returns the data with a one-hot owner strobe.
module m1_rd_arbiter #(
    parameter int unsigned N_REQ  = 3,
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en_i,
    input  logic [N_REQ-1:0]          req_i,
    input  logic [N_REQ*ADDR_W-1:0]   adr_i,
    output logic [N_REQ-1:0]          ack_o,
    output logic [N_REQ-1:0]          rvalid_o,
    output logic [DATA_W-1:0]         rdata_o,
    output logic [ADDR_W-1:0]         ram_adr_o,
    output logic                      ram_rd_o,
    input  logic [DATA_W-1:0]         ram_dat_i,
    output logic                      busy_o,
    output logic [1:0]                state_o
);

    localparam int unsigned PtrW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StRun   = 2'b01,
        StDrain = 2'b10
    } state_e;

    state_e              state_q;
    logic [PtrW-1:0]     ptr_q;
    logic                ram_rd_q;
    logic [ADDR_W-1:0]   ram_adr_q;
    logic [N_REQ-1:0]    tag_q [RD_LAT+1];
    logic [N_REQ-1:0]    rvalid_q;
    logic [DATA_W-1:0]   rdata_q;

    logic                grant;
    logic [PtrW-1:0]     win;
    logic [PtrW-1:0]     cand;
    logic [ADDR_W-1:0]   win_adr;
    logic [N_REQ-1:0]    ack;
    logic                in_flight;

    // Search starts one past the last winner; ptr_q resets to N_REQ-1 so requester 0 goes first.
    always_comb begin
        grant   = 1'b0;
        win     = '0;
        cand    = '0;
        win_adr = '0;
        ack     = '0;
        if (rst_n && state_q == StRun && en_i) begin
            for (int unsigned i = 1; i <= N_REQ; i++) begin
                cand = PtrW'((32'(ptr_q) + i) % N_REQ);
                if (!grant && req_i[cand]) begin
                    grant = 1'b1;
                    win   = cand;
                end
            end
        end
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (win == PtrW'(k)) begin
                win_adr = adr_i[k*ADDR_W +: ADDR_W];
            end
        end
        if (grant) begin
            ack[win] = 1'b1;
        end
    end

    always_comb begin
        in_flight = 1'b0;
        for (int unsigned s = 0; s <= RD_LAT; s++) begin
            in_flight = in_flight | (|tag_q[s]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            ptr_q     <= PtrW'(N_REQ - 1);
            ram_rd_q  <= 1'b0;
            ram_adr_q <= '0;
            rvalid_q  <= '0;
            rdata_q   <= '0;
            for (int unsigned s = 0; s <= RD_LAT; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            unique case (state_q)
                StIdle:  if (en_i) state_q <= StRun;
                StRun:   if (!en_i) state_q <= StDrain;
                StDrain: begin
                    if (en_i) begin
                        state_q <= StRun;
                    end else if (!busy_o) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase

            ram_rd_q <= grant;
            if (grant) begin
                ptr_q     <= win;
                ram_adr_q <= win_adr;
            end

            // Owner tag travels alongside the RAM read so the data can be routed back.
            tag_q[0] <= ack;
            for (int unsigned s = 1; s <= RD_LAT; s++) begin
                tag_q[s] <= tag_q[s-1];
            end

            rvalid_q <= tag_q[RD_LAT];
            if (|tag_q[RD_LAT]) begin
                rdata_q <= ram_dat_i;
            end
        end
    end

    assign ack_o     = ack;
    assign rvalid_o  = rvalid_q;
    assign rdata_o   = rdata_q;
    assign ram_adr_o = ram_adr_q;
    assign ram_rd_o  = ram_rd_q;
    assign busy_o    = in_flight | (|rvalid_q);
    assign state_o   = state_q;

endmodule

// File: tb/tb_m1_rd_arbiter.sv
// Directed bench for m1_rd_arbiter: one instance at RD_LAT=1 (3 requesters) and one at
// RD_LAT=2 (2 requesters), each backed by a behavioural RAM of matching latency.
module tb_m1_rd_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        en;
    logic [2:0]  req;
    logic [17:0] adr;
    logic [2:0]  ack;
    logic [2:0]  rvalid;
    logic [15:0] rdata;
    logic [5:0]  ram_adr;
    logic        ram_rd;
    logic [15:0] ram_dat;
    logic        busy;
    logic [1:0]  state;

    logic        en2;
    logic [1:0]  req2;
    logic [11:0] adr2;
    logic [1:0]  ack2;
    logic [1:0]  rvalid2;
    logic [15:0] rdata2;
    logic [5:0]  ram_adr2;
    logic        ram_rd2;
    logic [15:0] ram_dat2;
    logic        busy2;
    logic [1:0]  state2;

    logic [15:0] mem [64];
    logic [15:0] r1;
    logic [15:0] s1;
    logic [15:0] s2;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    m1_rd_arbiter #(.N_REQ(3), .ADDR_W(6), .DATA_W(16), .RD_LAT(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_i      (en),
        .req_i     (req),
        .adr_i     (adr),
        .ack_o     (ack),
        .rvalid_o  (rvalid),
        .rdata_o   (rdata),
        .ram_adr_o (ram_adr),
        .ram_rd_o  (ram_rd),
        .ram_dat_i (ram_dat),
        .busy_o    (busy),
        .state_o   (state)
    );

    m1_rd_arbiter #(.N_REQ(2), .ADDR_W(6), .DATA_W(16), .RD_LAT(2)) dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_i      (en2),
        .req_i     (req2),
        .adr_i     (adr2),
        .ack_o     (ack2),
        .rvalid_o  (rvalid2),
        .rdata_o   (rdata2),
        .ram_adr_o (ram_adr2),
        .ram_rd_o  (ram_rd2),
        .ram_dat_i (ram_dat2),
        .busy_o    (busy2),
        .state_o   (state2)
    );

    function automatic logic [15:0] memval(input int a);
        if (a == 5) return 16'hA5A5;
        return 16'h1000 + 16'(a) * 16'h0101;
    endfunction

    always @(posedge clk) begin
        r1 <= mem[ram_adr];
        s1 <= mem[ram_adr2];
        s2 <= s1;
    end
    assign ram_dat  = r1;
    assign ram_dat2 = s2;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [2:0] exp_seq [6];

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = memval(i);
        exp_seq[0] = 3'b001; exp_seq[1] = 3'b010; exp_seq[2] = 3'b100;
        exp_seq[3] = 3'b001; exp_seq[4] = 3'b010; exp_seq[5] = 3'b100;

        rst_n = 1'b0; en = 1'b0; req = '0; adr = '0;
        en2 = 1'b0; req2 = '0; adr2 = '0;
        tick(); tick();
        chk("rst_state", 32'(state), 32'h0);
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_rvalid", 32'(rvalid), 32'h0);
        chk("rst_ram_rd", 32'(ram_rd), 32'h0);
        chk("rst_ram_adr", 32'(ram_adr), 32'h0);
        chk("rst_rdata", 32'(rdata), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);

        // Single read, RD_LAT=1
        rst_n = 1'b1;
        tick();
        chk("idle_no_en", 32'(state), 32'h0);
        en = 1'b1;
        tick();
        chk("run_state", 32'(state), 32'h1);
        req = 3'b001; adr[5:0] = 6'h05;
        #1 chk("single_ack", 32'(ack), 32'h1);
        tick();
        req = '0;
        #1 chk("single_ack_clr", 32'(ack), 32'h0);
        chk("single_ram_rd", 32'(ram_rd), 32'h1);
        chk("single_ram_adr", 32'(ram_adr), 32'h05);
        chk("single_busy_t1", 32'(busy), 32'h1);
        tick();
        chk("single_ram_rd_off", 32'(ram_rd), 32'h0);
        chk("single_adr_hold", 32'(ram_adr), 32'h05);
        chk("single_rvalid_t2", 32'(rvalid), 32'h0);
        tick();
        chk("single_rvalid", 32'(rvalid), 32'h1);
        chk("single_rdata", 32'(rdata), 32'hA5A5);
        chk("single_busy_t3", 32'(busy), 32'h1);
        tick();
        chk("single_rvalid_off", 32'(rvalid), 32'h0);
        chk("single_rdata_hold", 32'(rdata), 32'hA5A5);
        chk("single_busy_off", 32'(busy), 32'h0);

        // Round robin from reset, all three requesting
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("rr_run", 32'(state), 32'h1);
        adr = {6'h22, 6'h21, 6'h20};
        for (int c = 0; c < 9; c++) begin
            req = (c < 6) ? 3'b111 : 3'b000;
            #1;
            if (c < 6) chk("rr_ack", 32'(ack), 32'(exp_seq[c]));
            else       chk("rr_ack_idle", 32'(ack), 32'h0);
            if (c >= 3) begin
                chk("rr_rvalid", 32'(rvalid), 32'(exp_seq[c-3]));
                chk("rr_rdata", 32'(rdata), 32'(memval(32 + (c - 3) % 3)));
            end
            tick();
        end

        // Requester 1 alone, four back-to-back reads
        for (int c = 0; c < 8; c++) begin
            req = (c < 4) ? 3'b010 : 3'b000;
            adr[11:6] = 6'(16 + c);
            #1;
            if (c < 4) chk("b2b_ack", 32'(ack), 32'h2);
            if (c >= 3 && c < 7) begin
                chk("b2b_rvalid", 32'(rvalid), 32'h2);
                chk("b2b_rdata", 32'(rdata), 32'(memval(16 + c - 3)));
            end
            if (c == 7) chk("b2b_rvalid_end", 32'(rvalid), 32'h0);
            tick();
        end

        // Drain with two reads in flight; last grant was 1, so 0 wins before 1
        adr[5:0] = 6'h30; adr[11:6] = 6'h31;
        req = 3'b011;
        #1 chk("drain_ack0", 32'(ack), 32'h1);
        tick();
        #1 chk("drain_ack1", 32'(ack), 32'h2);
        tick();
        en = 1'b0; req = 3'b001;
        #1 chk("en_fall_no_ack", 32'(ack), 32'h0);
        tick();
        chk("drain_state", 32'(state), 32'h2);
        chk("drain_no_ack", 32'(ack), 32'h0);
        chk("drain_busy", 32'(busy), 32'h1);
        chk("drain_rvalid0", 32'(rvalid), 32'h1);
        chk("drain_rdata0", 32'(rdata), 32'(memval(48)));
        tick();
        chk("drain_rvalid1", 32'(rvalid), 32'h2);
        chk("drain_rdata1", 32'(rdata), 32'(memval(49)));
        chk("drain_state2", 32'(state), 32'h2);
        tick();
        chk("drain_done_rv", 32'(rvalid), 32'h0);
        chk("drain_done_busy", 32'(busy), 32'h0);
        tick();
        chk("drain_idle", 32'(state), 32'h0);
        chk("idle_no_ack", 32'(ack), 32'h0);
        req = '0;

        // Reset right after a grant discards the read
        en = 1'b1;
        tick();
        req = 3'b100; adr[17:12] = 6'h07;
        #1 chk("rst_mid_ack", 32'(ack), 32'h4);
        tick();
        req = '0; rst_n = 1'b0;
        tick();
        rst_n = 1'b1; en = 1'b0;
        chk("rst_mid_state", 32'(state), 32'h0);
        chk("rst_mid_ram_rd", 32'(ram_rd), 32'h0);
        chk("rst_mid_ram_adr", 32'(ram_adr), 32'h0);
        chk("rst_mid_rdata", 32'(rdata), 32'h0);
        chk("rst_mid_busy", 32'(busy), 32'h0);
        for (int c = 0; c < 4; c++) begin
            chk("rst_mid_no_rvalid", 32'(rvalid), 32'h0);
            tick();
        end

        // RD_LAT=2 instance
        en2 = 1'b1;
        tick();
        req2 = 2'b01; adr2[5:0] = 6'h09;
        #1 chk("lat2_ack", 32'(ack2), 32'h1);
        tick();
        req2 = '0;
        chk("lat2_ram_rd", 32'(ram_rd2), 32'h1);
        chk("lat2_ram_adr", 32'(ram_adr2), 32'h09);
        tick();
        tick();
        chk("lat2_rvalid_t3", 32'(rvalid2), 32'h0);
        tick();
        chk("lat2_rvalid", 32'(rvalid2), 32'h1);
        chk("lat2_rdata", 32'(rdata2), 32'(memval(9)));
        tick();
        chk("lat2_rvalid_off", 32'(rvalid2), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
